demultiplexer4_hold: RTL

//   Write-side counterpart of the CPU's 32-bit 4:1 operand selector.

---
 rtl/demultiplexer4_hold.sv | 107 ++++++++++
 1 files changed

// File: rtl/demultiplexer4_hold.sv
// Routes one WIDTH-bit value into one of four registered holding slots, each with valid/ready.
// Optional DEMUX4_BROADCAST_EN adds a bcast input that writes all four slots at once.
module demux4_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data,
    output logic             valid
);
    // Write wins over pop so a same-cycle pop+write keeps the slot full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            if (wr)
                data <= data_in;
            if (wr)
                valid <= 1'b1;
            else if (rd)
                valid <= 1'b0;
        end
    end
endmodule

module demultiplexer4_hold #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               address0,
    input  logic               address1,
    input  logic [WIDTH-1:0]   in_data,
`ifdef DEMUX4_BROADCAST_EN
    input  logic               bcast,
`endif
    output logic [WIDTH-1:0]   out0,
    output logic [WIDTH-1:0]   out1,
    output logic [WIDTH-1:0]   out2,
    output logic [WIDTH-1:0]   out3,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [COUNT_W-1:0] wr_count
);
    localparam int NUM_SLOTS = 4;

    logic [1:0]                      sel;
    logic [NUM_SLOTS-1:0]            slot_free;
    logic [NUM_SLOTS-1:0]            wr_en;
    logic [NUM_SLOTS-1:0]            rd_en;
    logic [NUM_SLOTS-1:0][WIDTH-1:0] slot_data;
    logic                            accept;

    assign sel       = {address1, address0};
    assign slot_free = ~out_valid | out_ready;
    assign rd_en     = out_valid & out_ready;

`ifdef DEMUX4_BROADCAST_EN
    assign in_ready = bcast ? (&slot_free) : slot_free[sel];
`else
    assign in_ready = slot_free[sel];
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
`ifdef DEMUX4_BROADCAST_EN
            wr_en[i] = accept & (bcast | (sel == 2'(i)));
`else
            wr_en[i] = accept & (sel == 2'(i));
`endif
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        demux4_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (wr_en[i]),
            .rd      (rd_en[i]),
            .data_in (in_data),
            .data    (slot_data[i]),
            .valid   (out_valid[i])
        );
    end

    assign out0 = slot_data[0];
    assign out1 = slot_data[1];
    assign out2 = slot_data[2];
    assign out3 = slot_data[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wr_count <= '0;
        else if (accept)
            wr_count <= wr_count + 1'b1;
    end
endmodule
